fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit_pkg.sv | 13 +
 rtl/fetch_pc_unit_npc_select.sv | 31 +++
 rtl/fetch_pc_unit.sv | 90 +++++++++
 tb/tb_fetch_pc_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch PC front end.
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [3:0]  COND_BA     = 4'b1000;

endpackage

// File: rtl/fetch_pc_unit_npc_select.sv
// Next PC/nPC priority mux and delay-slot annul flush for the fetch stage.
module fetch_pc_unit_npc_select
  import fetch_pc_unit_pkg::*;
(
  input  logic        le,
  input  logic [31:0] npc_q,
  input  logic        branch_taken,
  input  logic        branch_cond,
  input  logic        branch_always,
  input  logic        branch_annul,
  input  logic [31:0] branch_target,
  input  logic        jc_en,
  input  logic [31:0] jc_target,
  output logic [31:0] pc_next,
  output logic [31:0] npc_next,
  output logic        flush
);

  always_comb begin
    pc_next  = npc_q;
    npc_next = npc_q + INSTR_BYTES;
    if (jc_en) begin
      npc_next = jc_target;
    end else if (branch_cond && branch_taken) begin
      npc_next = branch_target;
    end
    // Annul squashes the delay slot of an untaken branch, or of BA with a=1.
    flush = le & branch_cond & branch_annul & (~branch_taken | branch_always);
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage front end: SPARC PC/nPC registers, run/stall FSM and fetch counter.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LE,
  input  logic             branch_taken,
  input  logic             branch_cond,
  input  logic             branch_always,
  input  logic             branch_annul,
  input  logic [31:0]      branch_target,
  input  logic             jc_en,
  input  logic [31:0]      jc_target,
  output logic [31:0]      PC_out,
  output logic [31:0]      nPC_out,
  output logic             fetch_valid,
  output logic             IF_ID_flush,
  output logic [1:0]       state_out,
  output logic [CNT_W-1:0] fetch_count
);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      npc_q, npc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_sel, npc_sel;
  logic             flush_raw;
  logic             advance;

  fetch_pc_unit_npc_select u_npc_select (
    .le            (LE),
    .npc_q         (npc_q),
    .branch_taken  (branch_taken),
    .branch_cond   (branch_cond),
    .branch_always (branch_always),
    .branch_annul  (branch_annul),
    .branch_target (branch_target),
    .jc_en         (jc_en),
    .jc_target     (jc_target),
    .pc_next       (pc_sel),
    .npc_next      (npc_sel),
    .flush         (flush_raw)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    cnt_d   = cnt_q;
    // The S_RESET cycle only arms the FSM; the first advance happens in S_RUN.
    advance = LE && (state_q != S_RESET);
    unique case (state_q)
      S_RESET: state_d = S_RUN;
      S_RUN:   if (!LE) state_d = S_STALL;
      S_STALL: if (LE) state_d = S_RUN;
      default: state_d = S_RESET;
    endcase
    if (advance) begin
      pc_d  = pc_sel;
      npc_d = npc_sel;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC + INSTR_BYTES;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_out      = pc_q;
  assign nPC_out     = npc_q;
  assign state_out   = state_q;
  assign fetch_count = cnt_q;
  assign fetch_valid = ~reset & (state_q == S_RUN);
  assign IF_ID_flush = ~reset & flush_raw;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, wrap sequences and random run vs a model.
module tb_fetch_pc_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, LE, branch_taken, branch_cond, branch_always, branch_annul, jc_en;
  logic [31:0] branch_target, jc_target;
  logic [31:0] PC_out, nPC_out;
  logic        fetch_valid, IF_ID_flush;
  logic [1:0]  state_out;
  logic [31:0] fetch_count;

  logic [31:0] pc2, npc2;
  logic        fv2, fl2;
  logic [1:0]  st2;
  logic [1:0]  cnt2;

  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .LE(LE),
    .branch_taken(branch_taken), .branch_cond(branch_cond),
    .branch_always(branch_always), .branch_annul(branch_annul),
    .branch_target(branch_target), .jc_en(jc_en), .jc_target(jc_target),
    .PC_out(PC_out), .nPC_out(nPC_out), .fetch_valid(fetch_valid),
    .IF_ID_flush(IF_ID_flush), .state_out(state_out), .fetch_count(fetch_count)
  );

  fetch_pc_unit #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .LE(LE),
    .branch_taken(branch_taken), .branch_cond(branch_cond),
    .branch_always(branch_always), .branch_annul(branch_annul),
    .branch_target(branch_target), .jc_en(jc_en), .jc_target(jc_target),
    .PC_out(pc2), .nPC_out(npc2), .fetch_valid(fv2),
    .IF_ID_flush(fl2), .state_out(st2), .fetch_count(cnt2)
  );

  typedef struct {
    logic        rst, le, bc, bt, ba, an;
    logic [31:0] btgt;
    logic        jc;
    logic [31:0] jtgt;
    logic [31:0] e_pc, e_npc;
    logic [1:0]  e_st;
    logic        e_fv, e_fl;
    logic [31:0] e_cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural PC/nPC, count and mode (0 reset, 1 run, 2 stall).
  logic [31:0] m_pc, m_npc, m_cnt;
  int          m_st;

  // Expectations for the small-counter, high-reset-address instance.
  logic        chk2 = 1'b0;
  logic [31:0] e2_pc, e2_npc;
  logic [1:0]  e2_st, e2_cnt;
  logic        e2_fv;
  logic [31:0] w_pc  [6] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
  logic [31:0] w_npc [6] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC};
  logic [1:0]  w_st  [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
  logic [1:0]  w_cnt [6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic rst, le, bc, bt, ba, an, input logic [31:0] btgt,
                              input logic jc, input logic [31:0] jtgt,
                              input logic [31:0] pc, npc, input logic [1:0] st,
                              input logic fv, fl, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.le = le; v.bc = bc; v.bt = bt; v.ba = ba; v.an = an;
    v.btgt = btgt; v.jc = jc; v.jtgt = jtgt;
    v.e_pc = pc; v.e_npc = npc; v.e_st = st; v.e_fv = fv; v.e_fl = fl; v.e_cnt = cnt;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] pc, npc, input logic [1:0] st,
                                input logic fv, input logic [31:0] cnt);
    return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc, npc, st, fv, 1'b0, cnt);
  endfunction

  function automatic vec_t model_vec(input vec_t v);
    vec_t r = v;
    r.e_pc  = m_pc;
    r.e_npc = m_npc;
    r.e_st  = 2'(m_st);
    r.e_cnt = m_cnt;
    r.e_fv  = !v.rst && (m_st == 1);
    r.e_fl  = !v.rst && v.le && v.bc && v.an && (!v.bt || v.ba);
    return r;
  endfunction

  task automatic model_step(input vec_t v);
    if (v.rst) begin
      m_pc = 32'h0; m_npc = 32'h4; m_cnt = 32'h0; m_st = 0;
    end else begin
      if (m_st != 0 && v.le) begin
        m_pc  = m_npc;
        if (v.jc)                m_npc = v.jtgt;
        else if (v.bc && v.bt)   m_npc = v.btgt;
        else                     m_npc = m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      m_st = (m_st == 0) ? 1 : (v.le ? 1 : 2);
    end
  endtask

  task automatic apply(input vec_t v);
    reset = v.rst; LE = v.le; branch_cond = v.bc; branch_taken = v.bt;
    branch_always = v.ba; branch_annul = v.an; branch_target = v.btgt;
    jc_en = v.jc; jc_target = v.jtgt;
    @(negedge clk);
    check("pc",    PC_out,            v.e_pc);
    check("npc",   nPC_out,           v.e_npc);
    check("state", 32'(state_out),    32'(v.e_st));
    check("fv",    32'(fetch_valid),  32'(v.e_fv));
    check("flush", 32'(IF_ID_flush),  32'(v.e_fl));
    check("count", fetch_count,       v.e_cnt);
    if (chk2) begin
      check("w_pc",    pc2,         e2_pc);
      check("w_npc",   npc2,        e2_npc);
      check("w_state", 32'(st2),    32'(e2_st));
      check("w_count", 32'(cnt2),   32'(e2_cnt));
      check("w_fv",    32'(fv2),    32'(e2_fv));
      check("w_flush", 32'(fl2),    32'(IF_ID_flush));
    end
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  vec_t tbl [20];

  initial begin
    tbl[0]  = mk(1,1,1,0,0,1, 32'h80, 0, 32'h0,   32'h0,   32'h4,   2'd0, 0, 0, 0);
    tbl[1]  = idle(32'h0,   32'h4,   2'd0, 0, 0);
    tbl[2]  = idle(32'h0,   32'h4,   2'd1, 1, 0);
    tbl[3]  = idle(32'h4,   32'h8,   2'd1, 1, 1);
    tbl[4]  = mk(0,0,1,0,0,1, 32'h80, 1, 32'h300, 32'h8,   32'hC,   2'd1, 1, 0, 2);
    tbl[5]  = mk(0,0,1,0,0,1, 32'h80, 1, 32'h300, 32'h8,   32'hC,   2'd2, 0, 0, 2);
    tbl[6]  = idle(32'h8,   32'hC,   2'd2, 0, 2);
    tbl[7]  = idle(32'hC,   32'h10,  2'd1, 1, 3);
    tbl[8]  = mk(0,1,1,1,0,1, 32'h40, 0, 32'h0,   32'h10,  32'h14,  2'd1, 1, 0, 4);
    tbl[9]  = idle(32'h14,  32'h40,  2'd1, 1, 5);
    tbl[10] = mk(0,1,1,0,0,1, 32'h80, 0, 32'h0,   32'h40,  32'h44,  2'd1, 1, 1, 6);
    tbl[11] = idle(32'h44,  32'h48,  2'd1, 1, 7);
    tbl[12] = mk(0,1,1,1,1,1, 32'h100,0, 32'h0,   32'h48,  32'h4C,  2'd1, 1, 1, 8);
    tbl[13] = idle(32'h4C,  32'h100, 2'd1, 1, 9);
    tbl[14] = mk(0,1,1,1,1,0, 32'h200,0, 32'h0,   32'h100, 32'h104, 2'd1, 1, 0, 10);
    tbl[15] = idle(32'h104, 32'h200, 2'd1, 1, 11);
    tbl[16] = mk(0,1,1,0,0,1, 32'h600,1, 32'h500, 32'h200, 32'h204, 2'd1, 1, 1, 12);
    tbl[17] = idle(32'h204, 32'h500, 2'd1, 1, 13);
    tbl[18] = mk(1,1,1,0,0,1, 32'h80, 1, 32'h700, 32'h500, 32'h504, 2'd1, 0, 0, 14);
    tbl[19] = idle(32'h0,   32'h4,   2'd0, 0, 0);

    reset = 1'b1; LE = 1'b1; branch_cond = 1'b0; branch_taken = 1'b0;
    branch_always = 1'b0; branch_annul = 1'b0; branch_target = 32'h0;
    jc_en = 1'b0; jc_target = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_npc = 32'h4; m_cnt = 32'h0; m_st = 0;

    for (int i = 0; i < 20; i++) apply(tbl[i]);

    // Redirect near the top of the address space to exercise the 32-bit wrap.
    apply(model_vec(mk(0,1,0,0,0,0, 32'h0, 1, 32'hFFFF_FFF8, 0,0,0,0,0,0)));
    for (int i = 0; i < 3; i++) apply(model_vec(idle(0,0,0,0,0)));
    check("wrap_pc",  PC_out,  32'h0);
    check("wrap_npc", nPC_out, 32'h4);

    for (int i = 0; i < 400; i++) begin
      vec_t v;
      v = idle(0,0,0,0,0);
      v.rst  = ($urandom_range(0, 49) == 0);
      v.le   = ($urandom_range(0, 3) != 0);
      v.jc   = ($urandom_range(0, 9) == 0);
      v.bc   = ($urandom_range(0, 2) == 0);
      v.bt   = 1'($urandom_range(0, 1));
      v.ba   = 1'($urandom_range(0, 1));
      v.an   = 1'($urandom_range(0, 1));
      v.btgt = $urandom & 32'hFFFF_FFFC;
      v.jtgt = $urandom & 32'hFFFF_FFFC;
      apply(model_vec(v));
    end

    // Reset both instances, then idle to see the high reset address and a 2-bit count wrap.
    apply(model_vec(mk(1,1,0,0,0,0, 32'h0, 0, 32'h0, 0,0,0,0,0,0)));
    chk2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e2_pc = w_pc[k]; e2_npc = w_npc[k]; e2_st = w_st[k]; e2_cnt = w_cnt[k];
      e2_fv = (w_st[k] == 2'd1);
      apply(model_vec(idle(0,0,0,0,0)));
    end
    chk2 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
